// File: rtl/tag_tree_build.sv
// JPEG2000 tag-tree builder: collects a 2^LEVELS square leaf grid from a stream,
// reduces it level by level with min or max, and streams all nodes root-first.
module tag_tree_build #(
    parameter int VAL_W    = 5,
    parameter int LEVELS   = 3,
    parameter int MODE_MIN = 1,
    parameter int LVL_W    = $clog2(LEVELS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEVELS:0]   cfg_rows_i,
    input  logic [LEVELS:0]   cfg_cols_i,
    input  logic              s_axis_leaf_valid_i,
    input  logic              s_axis_leaf_last_i,
    input  logic [VAL_W-1:0]  s_axis_leaf_data_i,
    output logic              s_axis_leaf_ready_o,
    output logic              m_axis_node_valid_o,
    output logic              m_axis_node_last_o,
    output logic [VAL_W-1:0]  m_axis_node_data_o,
    output logic [LVL_W-1:0]  m_axis_node_level_o,
    input  logic              m_axis_node_ready_i,
    output logic              busy_o,
    output logic              err_o
);

    // Both streams: a beat moves on a clock edge where valid and ready are both high.
    // The node stream keeps data/level/last stable while valid is high and ready low.

    localparam int SIDE     = 1 << LEVELS;
    localparam int N_NODES  = ((1 << (2 * (LEVELS + 1))) - 1) / 3;
    localparam int LEAF_OFF = ((1 << (2 * LEVELS)) - 1) / 3;
    localparam int IDX_W    = $clog2(N_NODES);

    localparam logic [VAL_W-1:0]  PAD      = (MODE_MIN != 0) ? {VAL_W{1'b1}} : {VAL_W{1'b0}};
    localparam logic [LEVELS:0]   SIDE_L   = (LEVELS + 1)'(SIDE);
    localparam logic [LEVELS:0]   ONE_L    = (LEVELS + 1)'(1);
    localparam logic [LVL_W-1:0]  RED_LAST = LVL_W'(LEVELS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_NODES - 1);

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_REDUCE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    function automatic logic [VAL_W-1:0] op2(input logic [VAL_W-1:0] a, input logic [VAL_W-1:0] b);
        if (MODE_MIN != 0) return (a < b) ? a : b;
        else               return (a > b) ? a : b;
    endfunction

    // Node storage is flat in drain order: level l starts at (4^l - 1) / 3.
    function automatic logic [LVL_W-1:0] level_of(input int idx);
        logic [LVL_W-1:0] lv;
        lv = '0;
        for (int l = 1; l <= LEVELS; l++) begin
            if (idx >= ((1 << (2 * l)) - 1) / 3) lv = LVL_W'(l);
        end
        return lv;
    endfunction

    function automatic logic [LEVELS:0] clamp_dim(input logic [LEVELS:0] v);
        if (v == '0)     return ONE_L;
        if (v > SIDE_L)  return SIDE_L;
        return v;
    endfunction

    logic [1:0]         state_q;
    logic [LEVELS-1:0]  x_q;
    logic [LEVELS-1:0]  y_q;
    logic [LEVELS:0]    rows_q;
    logic [LEVELS:0]    cols_q;
    logic [LVL_W-1:0]   red_cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               err_q;
    logic [VAL_W-1:0]   tree_q  [N_NODES];
    logic [VAL_W-1:0]   red_val [LEAF_OFF];

    logic               first_beat;
    logic [LEVELS:0]    eff_rows;
    logic [LEVELS:0]    eff_cols;
    logic               x_last;
    logic               y_last;
    logic               count_done;
    logic               leaf_fire;
    logic               tile_end;
    logic               drain_fire;
    logic               drain_done;
    logic [LVL_W-1:0]   cur_lvl;
    logic [2*LEVELS-1:0] leaf_addr;

    // The tile geometry is taken live on the very first beat and held afterwards.
    assign first_beat = (x_q == '0) && (y_q == '0);
    assign eff_rows   = first_beat ? clamp_dim(cfg_rows_i) : rows_q;
    assign eff_cols   = first_beat ? clamp_dim(cfg_cols_i) : cols_q;
    assign x_last     = ({1'b0, x_q} == (eff_cols - ONE_L));
    assign y_last     = ({1'b0, y_q} == (eff_rows - ONE_L));
    assign count_done = x_last && y_last;
    assign leaf_fire  = (state_q == ST_FILL) && s_axis_leaf_valid_i;
    assign tile_end   = leaf_fire && (count_done || s_axis_leaf_last_i);
    assign drain_fire = (state_q == ST_DRAIN) && m_axis_node_ready_i;
    assign drain_done = drain_fire && (idx_q == IDX_LAST);
    assign cur_lvl    = RED_LAST - red_cnt_q;
    assign leaf_addr  = {y_q, x_q};

    genvar gl, gp;
    generate
        for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
            for (gp = 0; gp < (1 << (2 * gl)); gp++) begin : g_node
                localparam int SL = 1 << gl;
                localparam int NI = ((1 << (2 * gl)) - 1) / 3 + gp;
                localparam int CI = ((1 << (2 * (gl + 1))) - 1) / 3
                                    + 2 * (gp / SL) * 2 * SL + 2 * (gp % SL);
                assign red_val[NI] = op2(op2(tree_q[CI],          tree_q[CI + 1]),
                                         op2(tree_q[CI + 2 * SL], tree_q[CI + 2 * SL + 1]));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            x_q       <= '0;
            y_q       <= '0;
            rows_q    <= SIDE_L;
            cols_q    <= SIDE_L;
            red_cnt_q <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= leaf_fire && (count_done != s_axis_leaf_last_i);
            case (state_q)
                ST_FILL: begin
                    if (leaf_fire) begin
                        if (first_beat) begin
                            rows_q <= eff_rows;
                            cols_q <= eff_cols;
                        end
                        if (tile_end) begin
                            state_q   <= ST_REDUCE;
                            red_cnt_q <= '0;
                        end else if (x_last) begin
                            x_q <= '0;
                            y_q <= y_q + 1'b1;
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end
                end
                ST_REDUCE: begin
                    if (red_cnt_q == RED_LAST) begin
                        state_q <= ST_DRAIN;
                        idx_q   <= '0;
                    end else begin
                        red_cnt_q <= red_cnt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_fire) begin
                        if (drain_done) begin
                            state_q <= ST_FILL;
                            idx_q   <= '0;
                            x_q     <= '0;
                            y_q     <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NODES; i++) tree_q[i] <= PAD;
        end else begin
            if (leaf_fire) begin
                for (int i = 0; i < SIDE * SIDE; i++) begin
                    if (leaf_addr == (2 * LEVELS)'(i)) tree_q[LEAF_OFF + i] <= s_axis_leaf_data_i;
                end
            end
            // One level per cycle, from just above the leaves up to the root.
            if (state_q == ST_REDUCE) begin
                for (int i = 0; i < LEAF_OFF; i++) begin
                    if (level_of(i) == cur_lvl) tree_q[i] <= red_val[i];
                end
            end
            if (drain_done) begin
                for (int i = 0; i < SIDE * SIDE; i++) tree_q[LEAF_OFF + i] <= PAD;
            end
        end
    end

    assign s_axis_leaf_ready_o = (state_q == ST_FILL);
    assign busy_o              = (state_q != ST_FILL);
    assign m_axis_node_valid_o = (state_q == ST_DRAIN);
    assign m_axis_node_data_o  = m_axis_node_valid_o ? tree_q[idx_q] : '0;
    assign m_axis_node_level_o = m_axis_node_valid_o ? level_of(int'(idx_q)) : '0;
    assign m_axis_node_last_o  = m_axis_node_valid_o && (idx_q == IDX_LAST);
    assign err_o               = err_q;

endmodule

// File: tb/tb_tag_tree_build.sv
// Bench for tag_tree_build: min and max instances (LEVELS=2) share one stimulus,
// driven from a vector table plus a reset-during-drain sequence.
module tb_tag_tree_build;

    localparam int VAL_W   = 5;
    localparam int LEVELS  = 2;
    localparam int LVL_W   = 2;
    localparam int N_NODES = 21;

    typedef struct {
        logic [2:0]  rows;
        logic [2:0]  cols;
        int          nbeats;
        int          last_beat;
        bit          ramp;
        bit          stall;
        bit          exp_err;
        logic [4:0]  root_min;
        logic [4:0]  root_max;
        logic [19:0] l1_min;
        logic [19:0] l1_max;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       cfg_rows, cfg_cols;
    logic             s_valid, s_last;
    logic [VAL_W-1:0] s_data;
    logic             m_ready;

    logic             s_ready_mn, m_valid_mn, m_last_mn, busy_mn, err_mn;
    logic [VAL_W-1:0] m_data_mn;
    logic [LVL_W-1:0] m_level_mn;
    logic             s_ready_mx, m_valid_mx, m_last_mx, busy_mx, err_mx;
    logic [VAL_W-1:0] m_data_mx;
    logic [LVL_W-1:0] m_level_mx;

    tag_tree_build #(.VAL_W(VAL_W), .LEVELS(LEVELS), .MODE_MIN(1)) dut_min (
        .clk(clk), .rst_n(rst_n), .cfg_rows_i(cfg_rows), .cfg_cols_i(cfg_cols),
        .s_axis_leaf_valid_i(s_valid), .s_axis_leaf_last_i(s_last),
        .s_axis_leaf_data_i(s_data), .s_axis_leaf_ready_o(s_ready_mn),
        .m_axis_node_valid_o(m_valid_mn), .m_axis_node_last_o(m_last_mn),
        .m_axis_node_data_o(m_data_mn), .m_axis_node_level_o(m_level_mn),
        .m_axis_node_ready_i(m_ready), .busy_o(busy_mn), .err_o(err_mn)
    );

    tag_tree_build #(.VAL_W(VAL_W), .LEVELS(LEVELS), .MODE_MIN(0)) dut_max (
        .clk(clk), .rst_n(rst_n), .cfg_rows_i(cfg_rows), .cfg_cols_i(cfg_cols),
        .s_axis_leaf_valid_i(s_valid), .s_axis_leaf_last_i(s_last),
        .s_axis_leaf_data_i(s_data), .s_axis_leaf_ready_o(s_ready_mx),
        .m_axis_node_valid_o(m_valid_mx), .m_axis_node_last_o(m_last_mx),
        .m_axis_node_data_o(m_data_mx), .m_axis_node_level_o(m_level_mx),
        .m_axis_node_ready_i(m_ready), .busy_o(busy_mx), .err_o(err_mx)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_min_q[$];
    logic [7:0] exp_max_q[$];
    vec_t tv[6];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] c, input int nb, input int lb,
                                input bit ramp, input bit stall, input bit err,
                                input logic [4:0] rmin, input logic [4:0] rmax,
                                input logic [19:0] l1mn, input logic [19:0] l1mx);
        vec_t v;
        v.rows = r; v.cols = c; v.nbeats = nb; v.last_beat = lb; v.ramp = ramp; v.stall = stall;
        v.exp_err = err; v.root_min = rmin; v.root_max = rmax; v.l1_min = l1mn; v.l1_max = l1mx;
        return v;
    endfunction

    function automatic logic [4:0] op2(input logic [4:0] a, input logic [4:0] b, input bit is_min);
        if (is_min) return (a < b) ? a : b;
        return (a > b) ? a : b;
    endfunction

    function automatic int clampi(input logic [2:0] v);
        if (v == 3'd0) return 1;
        if (v > 3'd4) return 4;
        return int'(v);
    endfunction

    task automatic push_exp(input bit is_min, input logic [7:0] w);
        if (is_min) exp_min_q.push_back(w);
        else        exp_max_q.push_back(w);
    endtask

    // Reference: 4x4 grid as a 2-D array, reduced with explicit 2x2 windows.
    task automatic build_expected(input vec_t v);
        logic [4:0] leaf[4][4];
        logic [4:0] l1[2][2];
        logic [4:0] root, pad;
        int r_eff, c_eff, k;
        bit is_min;
        r_eff = clampi(v.rows);
        c_eff = clampi(v.cols);
        for (int m = 0; m < 2; m++) begin
            is_min = (m == 0);
            pad = is_min ? 5'd31 : 5'd0;
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) leaf[r][c] = pad;
            k = 0;
            for (int r = 0; r < r_eff; r++) begin
                for (int c = 0; c < c_eff; c++) begin
                    if (k < v.nbeats) leaf[r][c] = v.ramp ? 5'(k) : 5'd7;
                    k++;
                end
            end
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    l1[i][j] = op2(op2(leaf[2*i][2*j], leaf[2*i][2*j+1], is_min),
                                   op2(leaf[2*i+1][2*j], leaf[2*i+1][2*j+1], is_min), is_min);
                end
            end
            root = op2(op2(l1[0][0], l1[0][1], is_min), op2(l1[1][0], l1[1][1], is_min), is_min);
            push_exp(is_min, {1'b0, 2'd0, root});
            for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) push_exp(is_min, {1'b0, 2'd1, l1[i][j]});
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) push_exp(is_min, {(r == 3 && c == 3), 2'd2, leaf[r][c]});
            end
        end
    endtask

    task automatic send_tile(input vec_t v);
        @(posedge clk); #1;
        cfg_rows = v.rows;
        cfg_cols = v.cols;
        for (int k = 0; k < v.nbeats; k++) begin
            s_valid = 1'b1;
            s_data  = v.ramp ? 5'(k) : 5'd7;
            s_last  = (k + 1 == v.last_beat);
            @(negedge clk);
            check($sformatf("leaf_ready[%0d]", k), s_ready_mn, 1);
            @(posedge clk); #1;
            // Geometry must have been captured on the first beat only.
            if (k == 0) begin
                cfg_rows = 3'd1;
                cfg_cols = 3'd1;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        check("err_pulse_min", err_mn, int'(v.exp_err));
        check("err_pulse_max", err_mx, int'(v.exp_err));
        check("reduce1_valid", m_valid_mn, 0);
        check("reduce1_s_ready", s_ready_mn, 0);
        check("reduce1_busy", busy_mn, 1);
        @(negedge clk);
        check("err_width", err_mn, 0);
        check("reduce2_valid", m_valid_mn, 0);
        check("reduce2_busy", busy_mn, 1);
        @(negedge clk);
        check("drain_start_valid_min", m_valid_mn, 1);
        check("drain_start_valid_max", m_valid_mx, 1);
    endtask

    task automatic drain(input vec_t v);
        int hs, cyc;
        bit stalled;
        logic [7:0] held, got, exp;
        logic [4:0] root_mn, root_mx;
        logic [19:0] l1_mn, l1_mx;
        hs = 0; cyc = 0; stalled = 0; held = '0;
        root_mn = '0; root_mx = '0; l1_mn = '0; l1_mx = '0;
        while (hs < N_NODES && cyc < 200) begin
            m_ready = v.stall ? (cyc % 2 == 1) : 1'b1;
            #1;
            got = {m_last_mn, m_level_mn, m_data_mn};
            check("drain_valid", m_valid_mn, 1);
            check("drain_s_ready", s_ready_mn, 0);
            check("drain_busy", busy_mn, 1);
            if (stalled) check("stall_hold", got, held);
            if (m_ready && m_valid_mn) begin
                exp = (exp_min_q.size() > 0) ? exp_min_q.pop_front() : 8'hff;
                check($sformatf("node_min[%0d]", hs), got, exp);
                exp = (exp_max_q.size() > 0) ? exp_max_q.pop_front() : 8'hff;
                check($sformatf("node_max[%0d]", hs), {m_last_mx, m_level_mx, m_data_mx}, exp);
                if (hs == 0) begin
                    root_mn = m_data_mn;
                    root_mx = m_data_mx;
                end else if (hs <= 4) begin
                    l1_mn[5*(hs-1) +: 5] = m_data_mn;
                    l1_mx[5*(hs-1) +: 5] = m_data_mx;
                end
                hs++;
                stalled = 0;
            end else begin
                stalled = 1;
                held = got;
            end
            @(negedge clk);
            cyc++;
        end
        check("beat_count", hs, N_NODES);
        exp_min_q.delete();
        exp_max_q.delete();
        check("root_min", root_mn, v.root_min);
        check("root_max", root_mx, v.root_max);
        check("l1_min", l1_mn, v.l1_min);
        check("l1_max", l1_mx, v.l1_max);
        check("idle_valid", m_valid_mn, 0);
        check("idle_s_ready", s_ready_mn, 1);
        check("idle_busy", busy_mn, 0);
        m_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_rows = 3'd4; cfg_cols = 3'd4;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;

        tv[0] = mk(3'd4, 3'd4, 16, 16, 1, 0, 0, 5'd0, 5'd15,
                   {5'd10, 5'd8, 5'd2, 5'd0}, {5'd15, 5'd13, 5'd7, 5'd5});
        tv[1] = mk(3'd3, 3'd3, 9, 9, 0, 0, 0, 5'd7, 5'd7,
                   {5'd7, 5'd7, 5'd7, 5'd7}, {5'd7, 5'd7, 5'd7, 5'd7});
        tv[2] = mk(3'd4, 3'd4, 16, 16, 1, 1, 0, 5'd0, 5'd15,
                   {5'd10, 5'd8, 5'd2, 5'd0}, {5'd15, 5'd13, 5'd7, 5'd5});
        tv[3] = mk(3'd4, 3'd4, 5, 5, 1, 0, 1, 5'd0, 5'd4,
                   {5'd31, 5'd31, 5'd2, 5'd0}, {5'd0, 5'd0, 5'd3, 5'd4});
        tv[4] = mk(3'd4, 3'd4, 16, 0, 1, 0, 1, 5'd0, 5'd15,
                   {5'd10, 5'd8, 5'd2, 5'd0}, {5'd15, 5'd13, 5'd7, 5'd5});
        tv[5] = mk(3'd0, 3'd7, 4, 4, 1, 0, 0, 5'd0, 5'd3,
                   {5'd31, 5'd31, 5'd2, 5'd0}, {5'd0, 5'd0, 5'd3, 5'd1});

        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready_mn, 1);
        check("rst_m_valid", m_valid_mn, 0);
        check("rst_m_last", m_last_mn, 0);
        check("rst_m_data", m_data_mn, 0);
        check("rst_m_level", m_level_mn, 0);
        check("rst_busy", busy_mn, 0);
        check("rst_err", err_mn, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            build_expected(tv[i]);
            send_tile(tv[i]);
            drain(tv[i]);
        end

        // Reset while beat 10 (leaf 4) is on the node stream.
        send_tile(tv[0]);
        m_ready = 1'b1;
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("pre_reset_beat10", m_data_mn, 4);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", m_valid_mn, 0);
        check("midrst_last", m_last_mn, 0);
        check("midrst_data", m_data_mn, 0);
        check("midrst_s_ready", s_ready_mn, 1);
        check("midrst_busy", busy_mn, 0);
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        build_expected(tv[0]);
        send_tile(tv[0]);
        drain(tv[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
